// File: rtl/stream_demux4.sv
// stream_demux4
//   Routes each accepted input word to one of four output channels. The
//   destination is selected by in_sel, or the word goes to all four channels
//   when in_bcast is high. Each channel has a one-entry register slot, so an
//   output stage can hold one word while its consumer stalls. Stalled
//   channels never block unicast traffic aimed at another channel.
//
// Ports
//   clk            single clock, rising-edge state updates
//   rst            asynchronous active-high reset
//   in_valid       upstream offers a word
//   in_ready       word offered this cycle will be accepted
//   in_data        offered word (BUS_WIDTH bits)
//   in_sel         destination channel index (0..3)
//   in_bcast       deliver the word to all four channels
//   out_valid[i]   channel i holds a word
//   out_ready[i]   channel i consumer takes the word
//   out_data0..3   channel word registers
//   accept_count   accepted input transfers, modulo 256

module stream_demux4 #(
  parameter int BUS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BUS_WIDTH-1:0] in_data,
  input  logic [1:0]           in_sel,
  input  logic                 in_bcast,
  output logic [3:0]           out_valid,
  input  logic [3:0]           out_ready,
  output logic [BUS_WIDTH-1:0] out_data0,
  output logic [BUS_WIDTH-1:0] out_data1,
  output logic [BUS_WIDTH-1:0] out_data2,
  output logic [BUS_WIDTH-1:0] out_data3,
  output logic [7:0]           accept_count
);

  logic [3:0]           full;
  logic [3:0]           available;
  logic [3:0]           load_mask;
  logic                 in_xfer;
  logic [BUS_WIDTH-1:0] slot_data0;
  logic [BUS_WIDTH-1:0] slot_data1;
  logic [BUS_WIDTH-1:0] slot_data2;
  logic [BUS_WIDTH-1:0] slot_data3;

  // A slot can take a new word if it is empty or its current word leaves on
  // this same edge, which gives one word per cycle per channel without a
  // bubble. A broadcast needs every slot to be available so that it loads
  // all four or none.
  always_comb begin
    available = ~full | out_ready;
    in_ready  = in_bcast ? (&available) : available[in_sel];
    in_xfer   = in_valid && in_ready;
    load_mask = 4'b0000;
    if (in_xfer) begin
      if (in_bcast) begin
        load_mask = 4'b1111;
      end else begin
        load_mask = 4'b0001 << in_sel;
      end
    end
  end

  // A load always wins over an output transfer on the same slot; otherwise
  // a consumed word empties the slot and an unconsumed one is kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 4'b0000;
    end else begin
      full <= load_mask | (full & ~out_ready);
    end
  end

  // Data registers only change on a load, so a held word stays stable while
  // the consumer stalls and out_ready by itself never alters the data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_data0 <= '0;
      slot_data1 <= '0;
      slot_data2 <= '0;
      slot_data3 <= '0;
    end else begin
      if (load_mask[0]) slot_data0 <= in_data;
      if (load_mask[1]) slot_data1 <= in_data;
      if (load_mask[2]) slot_data2 <= in_data;
      if (load_mask[3]) slot_data3 <= in_data;
    end
  end

  // A broadcast counts as a single accepted transfer; the counter wraps
  // naturally at 256.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accept_count <= 8'd0;
    end else if (in_xfer) begin
      accept_count <= accept_count + 8'd1;
    end
  end

  assign out_valid = full;
  assign out_data0 = slot_data0;
  assign out_data1 = slot_data1;
  assign out_data2 = slot_data2;
  assign out_data3 = slot_data3;

endmodule

// File: tb/tb_stream_demux4.sv
// tb_stream_demux4
//   Directed bench for stream_demux4. The stimulus process drives words and
//   pushes each word it expects the block to accept onto a per-channel
//   expected queue; a separate monitor compares every presented output word
//   against the head of its channel queue and pops it when consumed.

module tb_stream_demux4;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [1:0] in_sel;
  logic       in_bcast;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [7:0] out_data0;
  logic [7:0] out_data1;
  logic [7:0] out_data2;
  logic [7:0] out_data3;
  logic [7:0] accept_count;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  logic [7:0] exp_q2[$];
  logic [7:0] exp_q3[$];

  stream_demux4 #(.BUS_WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_sel       (in_sel),
    .in_bcast     (in_bcast),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data0    (out_data0),
    .out_data1    (out_data1),
    .out_data2    (out_data2),
    .out_data3    (out_data3),
    .accept_count (accept_count)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic push_word(input int ch, input logic [7:0] d);
    case (ch)
      0: exp_q0.push_back(d);
      1: exp_q1.push_back(d);
      2: exp_q2.push_back(d);
      default: exp_q3.push_back(d);
    endcase
  endtask

  function automatic int q_size(input int ch);
    case (ch)
      0: return exp_q0.size();
      1: return exp_q1.size();
      2: return exp_q2.size();
      default: return exp_q3.size();
    endcase
  endfunction

  function automatic logic [7:0] q_front(input int ch);
    case (ch)
      0: return exp_q0[0];
      1: return exp_q1[0];
      2: return exp_q2[0];
      default: return exp_q3[0];
    endcase
  endfunction

  task automatic q_pop(input int ch);
    logic [7:0] dummy;
    case (ch)
      0: dummy = exp_q0.pop_front();
      1: dummy = exp_q1.pop_front();
      2: dummy = exp_q2.pop_front();
      default: dummy = exp_q3.pop_front();
    endcase
  endtask

  task automatic clear_queues();
    exp_q0.delete();
    exp_q1.delete();
    exp_q2.delete();
    exp_q3.delete();
  endtask

  // Called just after a rising edge. Drives one cycle of inputs, checks the
  // combinational in_ready at the falling edge against the hand-computed
  // value, records the expected word(s), and returns just after the next
  // rising edge so the caller sees the post-edge state.
  task automatic applyStimulus(input logic v, input logic [7:0] d,
                               input logic [1:0] s, input logic b,
                               input logic [3:0] ordy, input logic exp_rdy);
    in_valid  = v;
    in_data   = d;
    in_sel    = s;
    in_bcast  = b;
    out_ready = ordy;
    @(negedge clk);
    checkOutput("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    if (v && exp_rdy) begin
      if (b) begin
        for (int c = 0; c < 4; c++) push_word(c, d);
      end else begin
        push_word(int'(s), d);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [3:0] ordy, input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 8'h00, 2'd0, 1'b0, ordy, 1'b1);
  endtask

  // Monitor: every channel presenting a word must show the oldest expected
  // word for that channel; a consumed word is retired from the queue.
  always @(negedge clk) begin
    logic [7:0] od [4];
    od[0] = out_data0;
    od[1] = out_data1;
    od[2] = out_data2;
    od[3] = out_data3;
    if (!rst) begin
      for (int c = 0; c < 4; c++) begin
        if (out_valid[c]) begin
          if (q_size(c) == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL mon_unexpected ch%0d: got word 0x%0h, expected none", c, od[c]);
          end else begin
            checkOutput($sformatf("mon_data ch%0d", c), {24'd0, od[c]}, {24'd0, q_front(c)});
            if (out_ready[c]) q_pop(c);
          end
        end
      end
    end
  end

  initial begin
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_sel    = 2'd0;
    in_bcast  = 1'b0;
    out_ready = 4'b0000;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset state");
    checkOutput("rst out_valid", {28'd0, out_valid}, 32'h0);
    checkOutput("rst accept_count", {24'd0, accept_count}, 32'h0);
    checkOutput("rst out_data0", {24'd0, out_data0}, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] unicast");
    applyStimulus(1'b1, 8'h11, 2'd2, 1'b0, 4'b1111, 1'b1);
    checkOutput("uni out_valid", {28'd0, out_valid}, 32'h4);
    checkOutput("uni out_data2", {24'd0, out_data2}, 32'h11);
    checkOutput("uni accept_count", {24'd0, accept_count}, 32'd1);
    idle(4'b1111, 2);

    $display("[TB] backpressure");
    applyStimulus(1'b1, 8'hA5, 2'd1, 1'b0, 4'b1101, 1'b1);
    applyStimulus(1'b1, 8'h5A, 2'd1, 1'b0, 4'b1101, 1'b0);
    checkOutput("bp hold out_data1", {24'd0, out_data1}, 32'hA5);
    checkOutput("bp hold out_valid", {28'd0, out_valid}, 32'h2);
    applyStimulus(1'b1, 8'h5A, 2'd1, 1'b0, 4'b1111, 1'b1);
    checkOutput("bp swap out_valid", {28'd0, out_valid}, 32'h2);
    checkOutput("bp swap out_data1", {24'd0, out_data1}, 32'h5A);
    checkOutput("bp accept_count", {24'd0, accept_count}, 32'd3);
    idle(4'b1111, 2);

    $display("[TB] broadcast");
    applyStimulus(1'b1, 8'h3C, 2'd1, 1'b1, 4'b0000, 1'b1);
    checkOutput("bc out_valid", {28'd0, out_valid}, 32'hF);
    checkOutput("bc out_data0", {24'd0, out_data0}, 32'h3C);
    checkOutput("bc out_data1", {24'd0, out_data1}, 32'h3C);
    checkOutput("bc out_data2", {24'd0, out_data2}, 32'h3C);
    checkOutput("bc out_data3", {24'd0, out_data3}, 32'h3C);
    idle(4'b0111, 1);
    applyStimulus(1'b1, 8'hC3, 2'd0, 1'b1, 4'b0111, 1'b0);
    checkOutput("bc blocked out_valid", {28'd0, out_valid}, 32'h8);
    checkOutput("bc blocked out_data3", {24'd0, out_data3}, 32'h3C);
    checkOutput("bc blocked out_data0", {24'd0, out_data0}, 32'h3C);
    checkOutput("bc blocked accept_count", {24'd0, accept_count}, 32'd4);
    idle(4'b1111, 2);

    $display("[TB] isolation");
    applyStimulus(1'b1, 8'h77, 2'd0, 1'b0, 4'b1110, 1'b1);
    applyStimulus(1'b1, 8'h81, 2'd1, 1'b0, 4'b1110, 1'b1);
    applyStimulus(1'b1, 8'h82, 2'd2, 1'b0, 4'b1110, 1'b1);
    applyStimulus(1'b1, 8'h83, 2'd3, 1'b0, 4'b1110, 1'b1);
    applyStimulus(1'b1, 8'h84, 2'd1, 1'b0, 4'b1110, 1'b1);
    applyStimulus(1'b1, 8'h85, 2'd2, 1'b0, 4'b1110, 1'b1);
    checkOutput("iso out_valid", {28'd0, out_valid}, 32'h5);
    checkOutput("iso out_data0", {24'd0, out_data0}, 32'h77);
    applyStimulus(1'b1, 8'h99, 2'd0, 1'b0, 4'b1110, 1'b0);
    checkOutput("iso accept_count", {24'd0, accept_count}, 32'd10);
    idle(4'b1111, 2);

    $display("[TB] async reset");
    applyStimulus(1'b1, 8'hEE, 2'd0, 1'b1, 4'b0000, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst out_valid", {28'd0, out_valid}, 32'h0);
    checkOutput("arst out_data0", {24'd0, out_data0}, 32'h0);
    checkOutput("arst out_data3", {24'd0, out_data3}, 32'h0);
    checkOutput("arst accept_count", {24'd0, accept_count}, 32'h0);
    clear_queues();
    in_valid  = 1'b1;
    in_data   = 8'h55;
    in_sel    = 2'd0;
    in_bcast  = 1'b0;
    out_ready = 4'b0000;
    @(posedge clk);
    #1;
    checkOutput("arst held out_valid", {28'd0, out_valid}, 32'h0);
    checkOutput("arst held accept_count", {24'd0, accept_count}, 32'h0);
    in_valid = 1'b0;
    rst      = 1'b0;
    applyStimulus(1'b1, 8'h01, 2'd0, 1'b0, 4'b1111, 1'b1);
    checkOutput("post-rst accept_count", {24'd0, accept_count}, 32'd1);
    checkOutput("post-rst out_data0", {24'd0, out_data0}, 32'h01);

    $display("[TB] counter wrap");
    for (int i = 2; i <= 255; i++) begin
      applyStimulus(1'b1, 8'(i), 2'(i % 4), 1'b0, 4'b1111, 1'b1);
    end
    checkOutput("wrap 255", {24'd0, accept_count}, 32'd255);
    applyStimulus(1'b1, 8'hF0, 2'd3, 1'b0, 4'b1111, 1'b1);
    checkOutput("wrap 0", {24'd0, accept_count}, 32'd0);

    idle(4'b1111, 4);
    for (int c = 0; c < 4; c++) begin
      checkOutput($sformatf("drain ch%0d pending", c), 32'(q_size(c)), 32'd0);
    end
    checkOutput("drain out_valid", {28'd0, out_valid}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_demux4.md
STREAM_DEMUX4 -- requirements
Module: stream_demux4

Interface
REQ-001 Parameter: BUS_WIDTH, default 8, data width of input and every output channel.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: in_valid  input  1  upstream offers a word.
REQ-005 Port: in_ready  output  1  block accepts the offered word this cycle.
REQ-006 Port: in_data  input  BUS_WIDTH  offered word.
REQ-007 Port: in_sel  input  2  destination channel index, binary, bit 0 = LSB (00 = channel 0 ... 11 = channel 3).
REQ-008 Port: in_bcast  input  1  when high, word goes to all four channels; in_sel ignored.
REQ-009 Port: out_valid  output  4  bit i = channel i holds a word.
REQ-010 Port: out_ready  input  4  bit i = channel i consumer takes the word.
REQ-011 Port: out_data0..out_data3  output  BUS_WIDTH each  channel word registers.
REQ-012 Port: accept_count  output  8  number of accepted input transfers, modulo 256.

Function
REQ-013 Each channel i SHALL be a one-entry register slot: full[i] flag plus BUS_WIDTH data register; out_valid[i] = full[i]; out_data_i = slot data.
REQ-014 Slot i is "available" when !full[i] || out_ready[i].
REQ-015 in_ready SHALL be combinational: in_bcast=0 -> available[in_sel]; in_bcast=1 -> AND of available[0..3].
REQ-016 Input transfer occurs on a rising edge where in_valid && in_ready; no other input state is consumed.
REQ-017 On transfer with in_bcast=0: slot[in_sel] loads in_data, full[in_sel] <= 1; other slots unaffected by the input.
REQ-018 On transfer with in_bcast=1: all four slots load in_data, all full <= 1, in the same cycle.
REQ-019 Output transfer on channel i occurs on a rising edge where full[i] && out_ready[i]; if slot i is not loaded that cycle, full[i] <= 0.
REQ-020 Simultaneous output transfer and load on the same slot: slot takes new word, full stays 1 (throughput 1 word/cycle/channel, no bubble).
REQ-021 Latency: word accepted at edge N appears on out_data/out_valid after edge N (one cycle).
REQ-022 While full[i] && !out_ready[i], out_data_i and out_valid[i] SHALL hold stable.
REQ-023 Slot data registers SHALL NOT change except on a load; out_ready alone never alters data.
REQ-024 Broadcast blocked by any single full, not-ready channel: in_ready=0, no slot loads (all-or-nothing).
REQ-025 in_valid=0: no load regardless of in_ready; in_ready may still be high.
REQ-026 accept_count increments by 1 per input transfer (broadcast counts 1); 255 wraps to 0.
REQ-027 Channels drain independently; stall on one channel SHALL NOT block unicast traffic to another.

Reset
REQ-028 rst high SHALL immediately (asynchronously) clear full[3:0], all slot data to 0, accept_count to 0; hence out_valid=0000, out_data0..3=0.
REQ-029 Reset mid-operation discards held words; no output transfer is reported for them.
REQ-030 While rst high, no loads or count updates occur; after deassertion, first transfer is possible on the next rising edge.

Verification
REQ-031 Unicast: out_ready=1111, send 0x11 sel=2 -> next cycle out_valid=0100, out_data2=0x11, accept_count=1.
REQ-032 Backpressure: out_ready[1]=0, send 0xA5 sel=1, then 0x5A sel=1 -> in_ready=0 on second word, out_data1 holds 0xA5; raise out_ready[1] -> 0x5A accepted same edge, out_valid[1] stays 1.
REQ-033 Broadcast: all empty, send 0x3C bcast=1 -> out_valid=1111, all out_data=0x3C; with channel 3 full and out_ready[3]=0, broadcast -> in_ready=0, no slot changes.
REQ-034 Isolation: channel 0 stalled full; unicast stream to channels 1-3 -> each word accepted at 1/cycle, channel 0 unchanged.
REQ-035 Wrap: 256 accepted transfers from reset -> accept_count returns to 0.
REQ-036 Async reset: assert rst between edges with slots full -> out_valid=0000, out_data=0, accept_count=0 before next edge.
